aes_axis_framer: RTL and testbench

AXI-Stream framing stage directly upstream of the AES stream core. It takes a raw 32-bit payload stream from the DMA (MM2S) side and prepends the 32-bit command word. It cuts long messages into frames of at most `MAX_FRAME_BLKS` 128-bit blocks, and pads a trailing partial block. Every frame the core receives is therefore exactly one command word followed by 1..`MAX_FRAME_BLKS` whole blocks, with `tlast` on the final word.

---
 rtl/aes_axis_framer.sv | 163 ++++++++++++++++
 tb/tb_aes_axis_framer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_framer.sv
// rtl/aes_axis_framer.sv - frames a raw payload stream into command-prefixed
// whole-block frames for the AES stream core, with a registered 2-entry output slice.
module aes_axis_framer #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_FRAME_BLKS       = 512,
  parameter int BLK_CNT_WIDTH        = 9
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [31:0]                       cmd,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [3:0]                        s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [3:0]                        m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  output logic                              err_partial,
  output logic [15:0]                       frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND_CMD, SEND_PAYLOAD, PAD} state_t;

  localparam logic [BLK_CNT_WIDTH-1:0] BLK_LAST = BLK_CNT_WIDTH'(MAX_FRAME_BLKS - 1);

  state_t                            state, state_nxt;
  logic [31:0]                       cmd_reg;
  logic [1:0]                        word_cnt;
  logic [BLK_CNT_WIDTH-1:0]          blk_cnt;

  logic [1:0]                        slice_cnt, slice_cnt_nxt;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tail_tdata;
  logic [3:0]                        tail_tstrb;
  logic                              tail_tlast;

  logic                              wr_en;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   wr_tdata;
  logic [3:0]                        wr_tstrb;
  logic                              wr_tlast;
  logic                              word_inc;
  logic                              frame_end;
  logic                              partial_end;
  logic                              slice_room;
  logic                              s_fire;
  logic                              pop;
  logic                              unused_tstrb;

  assign unused_tstrb    = ^s00_axis_tstrb;
  assign slice_room      = (slice_cnt < 2'd2);
  assign pop             = m00_axis_tvalid && m00_axis_tready;
  assign s00_axis_tready = (state == SEND_PAYLOAD) && slice_room;
  assign s_fire          = s00_axis_tvalid && s00_axis_tready;

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    wr_tdata    = cmd_reg;
    wr_tstrb    = 4'hF;
    wr_tlast    = 1'b0;
    word_inc    = 1'b0;
    frame_end   = 1'b0;
    partial_end = 1'b0;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid) state_nxt = SEND_CMD;
      end
      SEND_CMD: begin
        if (slice_room) begin
          wr_en     = 1'b1;
          state_nxt = SEND_PAYLOAD;
        end
      end
      SEND_PAYLOAD: begin
        if (s_fire) begin
          wr_en    = 1'b1;
          wr_tdata = s00_axis_tdata;
          word_inc = 1'b1;
          if (word_cnt == 2'd3) begin
            frame_end = s00_axis_tlast || (blk_cnt == BLK_LAST);
            wr_tlast  = frame_end;
            if (frame_end) state_nxt = s00_axis_tlast ? IDLE : SEND_CMD;
          end else if (s00_axis_tlast) begin
            partial_end = 1'b1;
            state_nxt   = PAD;
          end
        end
      end
      PAD: begin
        if (slice_room) begin
          wr_en    = 1'b1;
          wr_tdata = '0;
          wr_tstrb = 4'h0;
          wr_tlast = (word_cnt == 2'd3);
          word_inc = 1'b1;
          if (word_cnt == 2'd3) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state       <= IDLE;
      cmd_reg     <= '0;
      word_cnt    <= '0;
      blk_cnt     <= '0;
      err_partial <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_partial <= partial_end;
      if (state == IDLE && s00_axis_tvalid) begin
        cmd_reg  <= cmd;
        word_cnt <= '0;
        blk_cnt  <= '0;
      end else if (word_inc) begin
        word_cnt <= word_cnt + 2'd1;
        // A continuation frame restarts its block count from zero.
        if (word_cnt == 2'd3) blk_cnt <= frame_end ? '0 : blk_cnt + 1'b1;
      end
    end
  end

  assign slice_cnt_nxt = slice_cnt + {1'b0, wr_en} - {1'b0, pop};

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      slice_cnt       <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      tail_tdata      <= '0;
      tail_tstrb      <= '0;
      tail_tlast      <= 1'b0;
      frames_sent     <= '0;
    end else begin
      slice_cnt       <= slice_cnt_nxt;
      m00_axis_tvalid <= (slice_cnt_nxt != 2'd0);
      if (pop && m00_axis_tlast) frames_sent <= frames_sent + 16'd1;
      // Head reloads from the write port when it is (or is about to become) the only entry.
      if (wr_en && (slice_cnt == 2'd0 || (slice_cnt == 2'd1 && pop))) begin
        m00_axis_tdata <= wr_tdata;
        m00_axis_tstrb <= wr_tstrb;
        m00_axis_tlast <= wr_tlast;
      end else if (pop && slice_cnt == 2'd2) begin
        m00_axis_tdata <= tail_tdata;
        m00_axis_tstrb <= tail_tstrb;
        m00_axis_tlast <= tail_tlast;
      end
      if (wr_en && slice_cnt == 2'd1 && !pop) begin
        tail_tdata <= wr_tdata;
        tail_tstrb <= wr_tstrb;
        tail_tlast <= wr_tlast;
      end
    end
  end

endmodule

// File: tb/tb_aes_axis_framer.sv
// tb/tb_aes_axis_framer.sv - randomized bench for aes_axis_framer against a
// frame-level reference model.
module tb_aes_axis_framer;

  localparam int FRAME_WORDS = 4 * 512;
  localparam int BUDGET      = 20000;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd;
  logic        s00_axis_tvalid;
  logic        s00_axis_tready;
  logic [31:0] s00_axis_tdata;
  logic [3:0]  s00_axis_tstrb;
  logic        s00_axis_tlast;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tstrb;
  logic        m00_axis_tlast;
  logic        err_partial;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  aes_axis_framer dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .cmd              (cmd),
    .s00_axis_tvalid  (s00_axis_tvalid),
    .s00_axis_tready  (s00_axis_tready),
    .s00_axis_tdata   (s00_axis_tdata),
    .s00_axis_tstrb   (s00_axis_tstrb),
    .s00_axis_tlast   (s00_axis_tlast),
    .m00_axis_tvalid  (m00_axis_tvalid),
    .m00_axis_tready  (m00_axis_tready),
    .m00_axis_tdata   (m00_axis_tdata),
    .m00_axis_tstrb   (m00_axis_tstrb),
    .m00_axis_tlast   (m00_axis_tlast),
    .err_partial      (err_partial),
    .frames_sent      (frames_sent)
  );

  beat_t       exp_q[$];
  logic [31:0] src_d[$];
  logic        src_l[$];
  logic        src_first[$];
  logic        src_partial[$];
  logic [31:0] src_cmd[$];

  int checks = 0, errors = 0;
  int vprob = 100, rprob = 100;
  int frames_exp = 0, err_exp = 0, err_seen = 0, s_fires = 0;
  logic        err_due = 1'b0;
  logic        stall_prev = 1'b0;
  logic [37:0] held = '0;

  task automatic add_msg(input logic [31:0] c, input int n, input logic [31:0] base);
    logic [31:0] words[$];
    int pos = 0;
    int take, pads;
    for (int i = 0; i < n; i++) words.push_back((base != 0) ? base + i : $urandom);
    for (int i = 0; i < n; i++) begin
      src_d.push_back(words[i]);
      src_l.push_back(i == n - 1);
      src_first.push_back(i == 0);
      src_partial.push_back((i == n - 1) && (n % 4 != 0));
      src_cmd.push_back(c);
    end
    while (pos < n) begin
      take = (n - pos > FRAME_WORDS) ? FRAME_WORDS : n - pos;
      pads = (take % 4 == 0) ? 0 : 4 - take % 4;
      exp_q.push_back(beat_t'{d: c, s: 4'hF, l: 1'b0});
      for (int j = 0; j < take; j++)
        exp_q.push_back(beat_t'{d: words[pos + j], s: 4'hF, l: (j == take - 1) && (pads == 0)});
      for (int k = 0; k < pads; k++)
        exp_q.push_back(beat_t'{d: 32'h0, s: 4'h0, l: (k == pads - 1)});
      pos += take;
      frames_exp++;
    end
    if (n % 4 != 0) err_exp++;
  endtask

  task automatic drive();
    if (src_d.size() != 0) begin
      s00_axis_tvalid = ($urandom_range(99) < vprob);
      s00_axis_tdata  = src_d[0];
      s00_axis_tlast  = src_l[0];
      cmd             = src_first[0] ? src_cmd[0] : $urandom;
    end else begin
      s00_axis_tvalid = 1'b0;
      s00_axis_tdata  = $urandom;
      s00_axis_tlast  = 1'b0;
      cmd             = $urandom;
    end
    s00_axis_tstrb  = 4'($urandom);
    m00_axis_tready = ($urandom_range(99) < rprob);
  endtask

  task automatic cycle();
    logic  fm, fs;
    beat_t got;
    @(negedge clk);
    checks++;
    assert (err_partial === err_due) else begin
      errors++;
      $error("FAIL err_partial: observed %0b expected %0b", err_partial, err_due);
    end
    if (err_partial) err_seen++;
    if (stall_prev) begin
      checks++;
      assert ({m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast} === held) else begin
        errors++;
        $error("FAIL stall_hold: observed %h expected %h",
               {m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}, held);
      end
    end
    fm = m00_axis_tvalid && m00_axis_tready;
    if (fm) begin
      got = beat_t'{d: m00_axis_tdata, s: m00_axis_tstrb, l: m00_axis_tlast};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat: observed %h expected no beat", got);
      end
      if (exp_q.size() != 0) begin
        checks++;
        assert (got === exp_q[0]) else begin
          errors++;
          $error("FAIL beat: observed d=%h s=%h l=%b expected d=%h s=%h l=%b",
                 got.d, got.s, got.l, exp_q[0].d, exp_q[0].s, exp_q[0].l);
        end
        void'(exp_q.pop_front());
      end
    end
    fs         = s00_axis_tvalid && s00_axis_tready;
    stall_prev = m00_axis_tvalid && !m00_axis_tready;
    held       = {m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast};
    @(posedge clk);
    #1;
    err_due = 1'b0;
    if (fs) begin
      err_due = src_partial[0];
      void'(src_d.pop_front());
      void'(src_l.pop_front());
      void'(src_first.pop_front());
      void'(src_partial.pop_front());
      void'(src_cmd.pop_front());
      s_fires++;
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((src_d.size() != 0 || exp_q.size() != 0) && n < BUDGET) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < BUDGET) else begin
      errors++;
      $error("FAIL %s_timeout: observed %0d cycles expected < %0d", tag, n, BUDGET);
    end
    repeat (3) cycle();
    checks++;
    assert (m00_axis_tvalid === 1'b0) else begin
      errors++;
      $error("FAIL %s_idle_tvalid: observed %b expected 0", tag, m00_axis_tvalid);
    end
    checks++;
    assert (frames_sent === 16'(frames_exp)) else begin
      errors++;
      $error("FAIL %s_frames: observed %0d expected %0d", tag, frames_sent, frames_exp);
    end
    checks++;
    assert (err_seen === err_exp) else begin
      errors++;
      $error("FAIL %s_err_count: observed %0d expected %0d", tag, err_seen, err_exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast} === 38'h0) else begin
      errors++;
      $error("FAIL %s_m00: observed %h expected 0", tag,
             {m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast});
    end
    checks++;
    assert ({s00_axis_tready, err_partial, frames_sent} === 18'h0) else begin
      errors++;
      $error("FAIL %s_misc: observed %h expected 0", tag, {s00_axis_tready, err_partial, frames_sent});
    end
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    cmd             = '0;
    s00_axis_tvalid = 1'b0;
    s00_axis_tdata  = '0;
    s00_axis_tstrb  = '0;
    s00_axis_tlast  = 1'b0;
    m00_axis_tready = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive();

    // Single block, no backpressure.
    add_msg(32'h0000_0020, 4, 32'hA0);
    drain("single");

    // Partial trailing block: six words, two pad words.
    add_msg(32'h0000_0030, 6, 32'h0);
    drain("partial");

    // Single block under 50% downstream backpressure.
    rprob = 50;
    add_msg(32'h0000_0020, 4, 32'hA0);
    drain("backpressure");

    // Back-to-back messages with a changed command word.
    rprob = 100;
    add_msg(32'h0000_0020, 4, 32'h0);
    add_msg(32'h0000_0021, 4, 32'h0);
    drain("b2b");

    // 513 blocks split into a full frame plus a one-block continuation.
    add_msg(32'h0000_0040, 2052, 32'h0);
    drain("split");

    // Random lengths and handshake rates, including a partial continuation frame.
    for (int m = 0; m < 6; m++) begin
      vprob = 30 + $urandom_range(70);
      rprob = 30 + $urandom_range(70);
      add_msg($urandom, 1 + $urandom_range(39), 32'h0);
      if (m == 3) add_msg($urandom, 2049, 32'h0);
      drain("random");
    end

    // Reset after two payload words, then a fresh message.
    vprob = 100;
    rprob = 100;
    add_msg(32'h0000_0055, 8, 32'h0);
    s_fires = 0;
    n = 0;
    while (s_fires < 2 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    assert (s_fires >= 2) else begin
      errors++;
      $error("FAIL midreset_start: observed %0d words expected 2", s_fires);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    src_d.delete();
    src_l.delete();
    src_first.delete();
    src_partial.delete();
    src_cmd.delete();
    frames_exp = 0;
    err_exp    = 0;
    err_seen   = 0;
    err_due    = 1'b0;
    stall_prev = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    add_msg(32'h0000_0011, 4, 32'h0);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
